sw_debouncer: RTL and testbench

- Conditions the raw board slide switches before they reach the single-cycle core's io_sw_i input.
- Per bit: 2-stage (parameterisable) synchroniser, then a debounce filter driven by a shared prescaler tick.
- Drives the core's switch input with a zero-extended, glitch-free 32-bit word.
- Also drives one-cycle rise/fall pulses, so the "enter" switch (bit 16) can be handled as an event.

---
 rtl/sw_pkg.sv | 26 ++
 rtl/sw_debounce_bit.sv | 94 +++++++++
 rtl/sw_debouncer.sv | 79 +++++++
 tb/tb_sw_debouncer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// ---------------------------------------------------------------------------
// sw_pkg
// Shared constants and helpers for the slide-switch conditioning path that
// feeds the single-cycle core's io_sw_i input.
//
// Contents:
//   SW_WORD_W      width of the switch word seen by the core
//   SW_NUM_DEFAULT number of physical switches on the board
//   SW_ENTER_BIT   the "enter" switch, handled by software as an event
//   SW_DATA_MSB    top bit of the operand field the software reads
//   sw_cnt_w()     width of a debounce counter able to hold 0..ticks
// ---------------------------------------------------------------------------
package sw_pkg;

    localparam int SW_WORD_W      = 32;
    localparam int SW_NUM_DEFAULT = 17;
    localparam int SW_ENTER_BIT   = 16;
    localparam int SW_DATA_MSB    = 15;

    // The counter only ever reaches ticks-1, but sizing for 0..ticks keeps the
    // width at least one bit even when a single tick qualifies a change.
    function automatic int sw_cnt_w(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// Conditions one raw switch bit: a synchroniser chain, then a filter that
// only accepts a new level once it has been seen on DEBOUNCE_TICKS
// consecutive prescaler ticks, then registered one-cycle edge pulses.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   raw_i     raw asynchronous switch level
//   tick_i    shared prescaler tick (one cycle wide)
//   stable_o  debounced level
//   rise_o    one-cycle pulse when stable_o goes 0->1
//   fall_o    one-cycle pulse when stable_o goes 1->0
// ---------------------------------------------------------------------------
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic tick_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W    = sw_cnt_w(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncBit;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign syncBit = sync_q[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser chain; the last stage is
    // the only copy of the input the filter is allowed to look at.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Filter next-state. Agreement with the stable level always clears the
    // count, so any bounce back restarts qualification from scratch. A
    // disagreement only advances on a tick, and the tick that would take the
    // count to DEBOUNCE_TICKS instead accepts the level and fires a pulse.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (syncBit == stable_q) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q == CNT_LAST)) begin
            stable_d = syncBit;
            cnt_d    = '0;
            rise_d   = syncBit;
            fall_d   = ~syncBit;
        end else if (tick_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Filter state and edge pulses are registered together so a pulse lines
    // up with the first cycle the new level is visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/sw_debouncer.sv
// ---------------------------------------------------------------------------
// sw_debouncer
// Turns the raw board slide switches into a glitch-free, zero-extended
// 32-bit word for the core, plus per-bit rise/fall event pulses.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   sw_raw_i      raw asynchronous switch levels [NUM_SW-1:0]
//   io_sw_o       debounced switch word, bits above NUM_SW tied to 0
//   sw_rise_o     one-cycle pulse per bit on a debounced 0->1
//   sw_fall_o     one-cycle pulse per bit on a debounced 1->0
//   sw_changed_o  OR of every rise/fall pulse this cycle
// ---------------------------------------------------------------------------
module sw_debouncer
    import sw_pkg::*;
#(
    parameter int NUM_SW         = SW_NUM_DEFAULT,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int TICK_DIV       = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_SW-1:0]    sw_raw_i,
    output logic [SW_WORD_W-1:0] io_sw_o,
    output logic [NUM_SW-1:0]    sw_rise_o,
    output logic [NUM_SW-1:0]    sw_fall_o,
    output logic                 sw_changed_o
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;
    logic [NUM_SW-1:0] stableBits;

    // Prescaler next-state. The wrap is explicit so a non-power-of-two
    // divider still ticks exactly once every TICK_DIV cycles.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    // Free-running prescaler shared by every bit; switch activity never
    // touches it, which is where the acceptance jitter comes from.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar b = 0; b < NUM_SW; b++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .raw_i    (sw_raw_i[b]),
            .tick_i   (tick),
            .stable_o (stableBits[b]),
            .rise_o   (sw_rise_o[b]),
            .fall_o   (sw_fall_o[b])
        );
    end

    // Zero-extend the debounced bits into the core's fixed-width word.
    always_comb begin
        io_sw_o             = '0;
        io_sw_o[NUM_SW-1:0] = stableBits;
    end

    assign sw_changed_o = |(sw_rise_o | sw_fall_o);

endmodule

// File: tb/tb_sw_debouncer.sv
// ---------------------------------------------------------------------------
// tb_sw_debouncer
// Drives the default-configured debouncer with directed and random switch
// activity and compares it each cycle against a window-based reference:
// a bit flips once its last DEBOUNCE_TICKS synchronised samples all differ
// from the accepted level. A second instance with a slow prescaler is used
// to check the acceptance delay window.
// ---------------------------------------------------------------------------
module tb_sw_debouncer;

    logic        clk = 1'b0;
    logic        rstN;
    logic [16:0] swRaw;
    logic [31:0] ioSw;
    logic [16:0] swRise;
    logic [16:0] swFall;
    logic        swChanged;

    logic [16:0] rawB;
    logic [31:0] ioSwB;
    logic [16:0] swRiseB;
    logic [16:0] swFallB;
    logic        swChangedB;

    int total = 0;
    int bad   = 0;

    logic [16:0] hist [6];
    logic [16:0] mStable;
    logic [16:0] mRise;
    logic [16:0] mFall;

    int obsPulses;
    int obsRise0;

    sw_debouncer dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .sw_raw_i     (swRaw),
        .io_sw_o      (ioSw),
        .sw_rise_o    (swRise),
        .sw_fall_o    (swFall),
        .sw_changed_o (swChanged)
    );

    sw_debouncer #(
        .TICK_DIV (10)
    ) dutSlow (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .sw_raw_i     (rawB),
        .io_sw_o      (ioSwB),
        .sw_rise_o    (swRiseB),
        .sw_fall_o    (swFallB),
        .sw_changed_o (swChangedB)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // One counted comparison; failures are tallied and reported.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Forget all history, as reset does to the synchroniser and filter.
    task automatic modelReset();
        for (int i = 0; i < 6; i++) hist[i] = '0;
        mStable = '0;
        mRise   = '0;
        mFall   = '0;
    endtask

    // Advance the reference by one clock edge. The synchronised value seen
    // at edge n is the raw value applied before edge n-2, so the last four
    // synchronised samples are hist[2..5].
    task automatic modelEdge();
        logic [16:0] mask;
        if (!rstN) begin
            modelReset();
        end else begin
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = swRaw;
            mask = '1;
            for (int j = 2; j < 6; j++) mask &= (hist[j] ^ mStable);
            mRise   = mask & ~mStable;
            mFall   = mask & mStable;
            mStable = mStable ^ mask;
        end
    endtask

    // Apply a raw value, let one edge pass, then check against the model.
    task automatic applyStimulus(input logic [16:0] value);
        swRaw = value;
        @(posedge clk);
        modelEdge();
        #1;
        obsPulses += $countones(swRise) + $countones(swFall);
        obsRise0  += int'(swRise[0]);
        checkOutput("io_sw",   ioSw,               {15'd0, mStable});
        checkOutput("rise",    {15'd0, swRise},    {15'd0, mRise});
        checkOutput("fall",    {15'd0, swFall},    {15'd0, mFall});
        checkOutput("changed", {31'd0, swChanged}, {31'd0, |(mRise | mFall)});
    endtask

    task automatic holdSteps(input logic [16:0] value, input int n);
        for (int i = 0; i < n; i++) applyStimulus(value);
    endtask

    // Flip bit 3 on the slow instance after a random phase offset and
    // measure how many edges pass before the debounced level follows.
    task automatic slowTrial(input logic level);
        int delay;
        repeat ($urandom_range(0, 9)) @(posedge clk);
        #1;
        rawB[3] = level;
        delay = -1;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            #1;
            if (ioSwB[3] === level) begin
                delay = e;
                break;
            end
        end
        total++;
        assert (delay >= 32 && delay <= 41)
        else begin
            bad++;
            $error("[TB] FAIL slow_delay observed=%0d expected=32..41", delay);
        end
        checkOutput("slow_rise",    {15'd0, swRiseB},    level ? 32'h0000_0008 : 32'h0);
        checkOutput("slow_fall",    {15'd0, swFallB},    level ? 32'h0 : 32'h0000_0008);
        checkOutput("slow_changed", {31'd0, swChangedB}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("slow_pulse_end", {31'd0, swChangedB}, 32'd0);
    endtask

    initial begin
        logic [16:0] cur;
        int          hold;

        $display("[TB] start");
        modelReset();
        obsPulses = 0;
        obsRise0  = 0;
        rawB      = '0;

        // Reset held with all switches on: nothing may leak through.
        rstN  = 1'b0;
        swRaw = 17'h1FFFF;
        #150;
        checkOutput("rst_io",      ioSw,               32'h0);
        checkOutput("rst_rise",    {15'd0, swRise},    32'h0);
        checkOutput("rst_changed", {31'd0, swChanged}, 32'h0);
        rstN = 1'b1;
        holdSteps(17'h1FFFF, 5);
        checkOutput("post_rst_edge5", ioSw, 32'h0);
        applyStimulus(17'h1FFFF);
        checkOutput("post_rst_io",      ioSw,               32'h0001_FFFF);
        checkOutput("post_rst_rise",    {15'd0, swRise},    32'h0001_FFFF);
        checkOutput("post_rst_changed", {31'd0, swChanged}, 32'd1);
        applyStimulus(17'h1FFFF);
        checkOutput("post_rst_rise_end", {15'd0, swRise}, 32'h0);

        // Clean change: everything off, then enter + 93, then enter released.
        holdSteps(17'h0, 8);
        checkOutput("all_off", ioSw, 32'h0);
        holdSteps(17'h1005D, 5);
        checkOutput("clean_early", ioSw, 32'h0);
        applyStimulus(17'h1005D);
        checkOutput("clean_io",   ioSw,            32'h0001_005D);
        checkOutput("clean_rise", {15'd0, swRise}, 32'h0001_005D);
        holdSteps(17'h0005D, 6);
        checkOutput("enter_drop_io",   ioSw,            32'h0000_005D);
        checkOutput("enter_drop_fall", {15'd0, swFall}, 32'h0001_0000);

        // Bounce on bit 0: 3 high / 1 low, four times, then a steady high.
        holdSteps(17'h0005C, 8);
        obsRise0 = 0;
        for (int r = 0; r < 4; r++) begin
            holdSteps(17'h0005D, 3);
            applyStimulus(17'h0005C);
        end
        holdSteps(17'h0005D, 5);
        checkOutput("bounce_edge4", {31'd0, ioSw[0]}, 32'd0);
        applyStimulus(17'h0005D);
        checkOutput("bounce_edge5", {31'd0, ioSw[0]}, 32'd1);
        holdSteps(17'h0005D, 3);
        checkOutput("bounce_rise_cnt", obsRise0, 32'd1);

        // Three-cycle glitch on bit 5 must vanish completely.
        obsPulses = 0;
        holdSteps(17'h0007D, 3);
        holdSteps(17'h0005D, 8);
        checkOutput("glitch_io",     ioSw,      32'h0000_005D);
        checkOutput("glitch_pulses", obsPulses, 32'd0);

        // Random switch activity, each level held 1..7 cycles.
        cur = 17'h0005D;
        for (int k = 0; k < 40; k++) begin
            cur  = cur ^ 17'($urandom() & 32'h0001_FFFF);
            hold = $urandom_range(1, 7);
            holdSteps(cur, hold);
        end

        // Mid-qualification reset with a new pattern pending.
        holdSteps(17'h1005D, 8);
        checkOutput("pre_mid_rst", ioSw, 32'h0001_005D);
        holdSteps(17'h1FEA6, 3);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("mid_rst_io",   ioSw,               32'h0);
        checkOutput("mid_rst_chg",  {31'd0, swChanged}, 32'h0);
        holdSteps(17'h1FEA6, 2);
        #3;
        rstN = 1'b1;
        holdSteps(17'h1FEA6, 5);
        checkOutput("mid_rel_early", ioSw, 32'h0);
        applyStimulus(17'h1FEA6);
        checkOutput("mid_rel_io",   ioSw,            32'h0001_FEA6);
        checkOutput("mid_rel_rise", {15'd0, swRise}, 32'h0001_FEA6);

        // Slow prescaler: acceptance lands 32..41 edges after the step.
        checkOutput("slow_idle", ioSwB, 32'h0);
        slowTrial(1'b1);
        slowTrial(1'b0);
        slowTrial(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
